// File: rtl/mem_io_bridge.sv
// CPU-to-memory/IO bridge: decodes a held CPU request onto a synchronous
// word RAM or a small set of memory-mapped peripherals (led/sw, seg
// display register, free-running counter) and returns a one-cycle
// completion pulse. Unmapped accesses complete like peripherals and set a
// sticky bus error.
module mem_io_bridge #(
  parameter int unsigned RAM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] seg,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_WR = 2'd1,
    RAM_RD = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wait-counter value on the final RAM_RD cycle.
  localparam logic [3:0] WAIT_LAST = 4'(RAM_LAT - 1);

  state_t      state_q,    state_d;
  logic [3:0]  waitCnt_q,  waitCnt_d;
  logic [31:0] dataIn_q,   dataIn_d;
  logic        mioReady_q, mioReady_d;
  logic [9:0]  ramAddr_q,  ramAddr_d;
  logic [31:0] ramDin_q,   ramDin_d;
  logic        ramWe_q,    ramWe_d;
  logic [15:0] led_q,      led_d;
  logic [31:0] seg_q,      seg_d;
  logic [31:0] counter_q,  counter_d;
  logic        busErr_q,   busErr_d;

  logic selRam;
  logic selSeg;
  logic selLed;
  logic selCnt;

  // Address bits that play no part in decode (word RAM is only 1K deep,
  // byte offset is ignored).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{Addr_out[27:12], Addr_out[1:0]};

  assign selRam = (Addr_out[31:28] == 4'h0);
  assign selSeg = (Addr_out[31:28] == 4'hE);
  assign selLed = (Addr_out[31:28] == 4'hF) && !Addr_out[2];
  assign selCnt = (Addr_out[31:28] == 4'hF) &&  Addr_out[2];

  // Next-state logic: transaction sequencing, peripheral updates and counter.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    dataIn_d   = dataIn_q;
    mioReady_d = 1'b0;
    ramAddr_d  = ramAddr_q;
    ramDin_d   = ramDin_q;
    ramWe_d    = 1'b0;
    led_d      = led_q;
    seg_d      = seg_q;
    counter_d  = counter_q + 32'd1;
    busErr_d   = busErr_q;

    unique case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
          if (selRam) begin
            ramAddr_d = Addr_out[11:2];
            ramDin_d  = Data_out;
            waitCnt_d = 4'd0;
            if (mem_w) begin
              state_d = RAM_WR;
              ramWe_d = 1'b1;
            end else begin
              state_d = RAM_RD;
            end
          end else begin
            state_d    = DONE;
            mioReady_d = 1'b1;
            if (selSeg) begin
              if (mem_w) seg_d    = Data_out;
              else       dataIn_d = seg_q;
            end else if (selLed) begin
              if (mem_w) led_d    = Data_out[15:0];
              else       dataIn_d = {16'h0000, sw};
            end else if (selCnt) begin
              if (mem_w) counter_d = Data_out;
              else       dataIn_d  = counter_q;
            end else begin
              busErr_d = 1'b1;
              if (!mem_w) dataIn_d = 32'h0000_0000;
            end
          end
        end
      end
      RAM_WR: begin
        state_d    = DONE;
        mioReady_d = 1'b1;
      end
      RAM_RD: begin
        if (waitCnt_q == WAIT_LAST) begin
          dataIn_d   = ram_dout;
          waitCnt_d  = 4'd0;
          state_d    = DONE;
          mioReady_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset dominates any request or load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      dataIn_q   <= 32'h0;
      mioReady_q <= 1'b0;
      ramAddr_q  <= 10'h0;
      ramDin_q   <= 32'h0;
      ramWe_q    <= 1'b0;
      led_q      <= 16'h0;
      seg_q      <= 32'h0;
      counter_q  <= 32'h0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      dataIn_q   <= dataIn_d;
      mioReady_q <= mioReady_d;
      ramAddr_q  <= ramAddr_d;
      ramDin_q   <= ramDin_d;
      ramWe_q    <= ramWe_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
      counter_q  <= counter_d;
      busErr_q   <= busErr_d;
    end
  end

  assign Data_in   = dataIn_q;
  assign MIO_ready = mioReady_q;
  assign ram_addr  = ramAddr_q;
  assign ram_din   = ramDin_q;
  assign ram_we    = ramWe_q;
  assign led       = led_q;
  assign seg       = seg_q;
  assign bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: a transaction-level model (latency per access
// class, address map, counter, sticky error) predicts every output each
// cycle, and directed transactions pin literal values.
module tb_mem_io_bridge;

  localparam int RAM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] seg;
  logic        bus_err;

  mem_io_bridge #(.RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw), .led(led),
    .seg(seg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  bit swRandom = 1'b0;
  logic [15:0] swFixed = 16'h0;

  // Background content of never-written RAM words, distinct per address.
  function automatic logic [31:0] scramble(input logic [9:0] a);
    return 32'h9E37_79B9 * (32'(a) + 32'd1);
  endfunction

  // External synchronous RAM, one cycle from address to data.
  bit [31:0] tbRamX [1024];
  always @(posedge clk) begin
    if (ram_we) tbRamX[ram_addr] <= ram_din ^ scramble(ram_addr);
    ram_dout <= tbRamX[ram_addr] ^ scramble(ram_addr);
  end

  // Switch inputs change away from the sampling edge.
  always @(negedge clk) sw = swRandom ? 16'($urandom) : swFixed;

  // Behavioural model state
  logic [31:0] modelMem [int];
  bit          mActive;
  int          mAge;
  int          mLat;
  bit          mIsRam;
  bit          mWrite;
  logic [31:0] mPending;
  logic [31:0] mDataIn;
  logic [15:0] mLed;
  logic [31:0] mSeg;
  logic [31:0] mCnt;
  bit          mErr;
  logic [9:0]  mRamAddr;
  logic [31:0] mRamDin;

  function automatic logic [31:0] memRead(input logic [9:0] a);
    if (modelMem.exists(int'(a))) return modelMem[int'(a)];
    return scramble(a);
  endfunction

  // Transaction-level prediction, advanced once per rising edge.
  always @(posedge clk) begin : model
    logic [31:0] cntBefore;
    if (reset) begin
      mActive = 0; mAge = 0; mLat = 1; mIsRam = 0; mWrite = 0;
      mDataIn = 32'h0; mLed = 16'h0; mSeg = 32'h0; mCnt = 32'h0;
      mErr = 0; mRamAddr = 10'h0; mRamDin = 32'h0; mPending = 32'h0;
    end else begin
      cntBefore = mCnt;
      mCnt = mCnt + 32'd1;
      if (mActive) begin
        if (mAge == mLat) mActive = 0;
        else mAge++;
      end else if (CPU_MIO) begin
        mActive = 1; mAge = 1; mWrite = mem_w; mIsRam = 0; mLat = 1;
        mPending = 32'h0;
        case (Addr_out[31:28])
          4'h0: begin
            mIsRam = 1;
            mRamAddr = Addr_out[11:2];
            mRamDin = Data_out;
            mLat = mem_w ? 2 : RAM_LAT + 1;
            if (mem_w) modelMem[int'(Addr_out[11:2])] = Data_out;
            else mPending = memRead(Addr_out[11:2]);
          end
          4'hE: begin
            if (mem_w) mSeg = Data_out; else mPending = mSeg;
          end
          4'hF: begin
            if (Addr_out[2]) begin
              if (mem_w) mCnt = Data_out; else mPending = cntBefore;
            end else begin
              if (mem_w) mLed = Data_out[15:0]; else mPending = {16'h0, sw};
            end
          end
          default: mErr = 1;
        endcase
      end
      if (mActive && mAge == mLat && !mWrite) mDataIn = mPending;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("MIO_ready", 32'(MIO_ready), 32'(mActive && mAge == mLat));
      checkOutput("ram_we", 32'(ram_we), 32'(mActive && mIsRam && mWrite && mAge == 1));
      checkOutput("Data_in", Data_in, mDataIn);
      checkOutput("led", 32'(led), 32'(mLed));
      checkOutput("seg", seg, mSeg);
      checkOutput("bus_err", 32'(bus_err), 32'(mErr));
      if (mActive && mIsRam) begin
        checkOutput("ram_addr", 32'(ram_addr), 32'(mRamAddr));
        checkOutput("ram_din", ram_din, mRamDin);
      end
    end
  end

  // Issue one request, hold it until MIO_ready, report data and latency.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int lat);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = w; Addr_out = a; Data_out = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MIO_ready && lat < 40);
    checks++;
    if (!MIO_ready) begin
      failures++;
      $display("[TB] FAIL ready_timeout actual=none required=pulse addr=%h", a);
    end
    rd = Data_in;
    CPU_MIO = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    int r;
    a = $urandom;
    r = $urandom_range(0, 5);
    case (r)
      0: begin a[31:28] = 4'h0; a[11:2] = 10'($urandom_range(0, 15)); end
      1: a[31:28] = 4'h0;
      2: a[31:28] = 4'hE;
      3, 4: a[31:28] = 4'hF;
      default: a[31:28] = 4'($urandom_range(1, 13));
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    int lat;
    reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0; Addr_out = 32'h0; Data_out = 32'h0;
    @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_Data_in", Data_in, 32'h0);
    checkOutput("rst_MIO_ready", 32'(MIO_ready), 32'h0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("rst_ram_din", ram_din, 32'h0);
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_seg", seg, 32'h0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'h0);
    reset = 1'b0;

    // RAM write then read of word 4
    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, rd, lat);
    checkOutput("ramwr_latency", 32'(lat), 32'd2);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    checkOutput("ramrd_latency", 32'(lat), 32'd3);
    checkOutput("ramrd_data", rd, 32'h1234_5678);
    checkOutput("ramrd_addr", 32'(ram_addr), 32'h4);

    // Top word of RAM
    applyStimulus(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, rd, lat);
    checkOutput("ramwr_top_latency", 32'(lat), 32'd2);
    checkOutput("ramwr_top_addr", 32'(ram_addr), 32'h3FF);
    checkOutput("ramwr_top_din", ram_din, 32'hA5A5_A5A5);
    checkOutput("ramwr_keeps_Data_in", Data_in, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_0FFC, 32'h0, rd, lat);
    checkOutput("ramrd_top_data", rd, 32'hA5A5_A5A5);

    // led / sw
    applyStimulus(1'b1, 32'hF000_0000, 32'h0001_ABCD, rd, lat);
    checkOutput("led_write", 32'(led), 32'h0000_ABCD);
    checkOutput("led_latency", 32'(lat), 32'd1);
    swFixed = 16'h00FF;
    applyStimulus(1'b0, 32'hF000_0000, 32'h0, rd, lat);
    checkOutput("sw_read", rd, 32'h0000_00FF);
    checkOutput("sw_latency", 32'(lat), 32'd1);

    // seg
    applyStimulus(1'b1, 32'hE000_0000, 32'hDEAD_BEEF, rd, lat);
    checkOutput("seg_write", seg, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'hE000_0003, 32'h0, rd, lat);
    checkOutput("seg_read", rd, 32'hDEAD_BEEF);

    // Counter: load wins over increment, then wrap through zero
    applyStimulus(1'b1, 32'hF000_0004, 32'h1234_5678, rd, lat);
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    checkOutput("cnt_load_collision", rd, 32'h1234_5679);
    applyStimulus(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat);
    @(negedge clk);
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    checkOutput("cnt_wrap", rd, 32'h0000_0000);

    // Unmapped read, error stays sticky
    applyStimulus(1'b0, 32'h5000_0000, 32'h0, rd, lat);
    checkOutput("unmapped_data", rd, 32'h0);
    checkOutput("unmapped_latency", 32'(lat), 32'd1);
    checkOutput("unmapped_err", 32'(bus_err), 32'h1);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    checkOutput("err_sticky", 32'(bus_err), 32'h1);

    // Reset in the middle of a RAM read
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h0000_0FFC;
    @(negedge clk);
    reset = 1'b1; CPU_MIO = 1'b0;
    @(negedge clk);
    checkOutput("abort_MIO_ready", 32'(MIO_ready), 32'h0);
    checkOutput("abort_ram_we", 32'(ram_we), 32'h0);
    checkOutput("abort_Data_in", Data_in, 32'h0);
    checkOutput("abort_bus_err", 32'(bus_err), 32'h0);
    checkOutput("abort_led", 32'(led), 32'h0);
    checkOutput("abort_ram_addr", 32'(ram_addr), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 32'h0000_0FFC, 32'h0, rd, lat);
    checkOutput("after_abort_latency", 32'(lat), 32'd3);
    checkOutput("after_abort_data", rd, 32'hA5A5_A5A5);

    // Randomized traffic
    swRandom = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        mem_w = 1'($urandom); Addr_out = $urandom; Data_out = $urandom;
      end
      applyStimulus(1'($urandom), randAddr(), $urandom, rd, lat);
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter RAM_LAT, default 2, meaning RAM read latency in cycles (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port CPU_MIO  input  1  CPU bus request, held high until MIO_ready.
REQ-005 SHALL have port mem_w  input  1  1 = write, 0 = read; sampled with CPU_MIO.
REQ-006 SHALL have port Addr_out  input  32  CPU byte address.
REQ-007 SHALL have port Data_out  input  32  CPU write data.
REQ-008 SHALL have port Data_in  output  32  read data to CPU.
REQ-009 SHALL have port MIO_ready  output  1  one-cycle transaction-complete pulse.
REQ-010 SHALL have ports ram_addr  output  10, ram_din  output  32, ram_we  output  1, ram_dout  input  32: synchronous word RAM.
REQ-011 SHALL have ports sw  input  16 (switches), led  output  16, seg  output  32 (display register), bus_err  output  1.

Function
REQ-012 SHALL decode on Addr_out[31:28]: 0x0 = RAM; 0xE = seg register; 0xF with Addr_out[2]=0 = led/sw; 0xF with Addr_out[2]=1 = counter; all else unmapped; Addr_out[1:0] ignored.
REQ-013 SHALL drive ram_addr = Addr_out[11:2] and ram_din = Data_out, latched at request acceptance.
REQ-014 SHALL implement FSM IDLE, RAM_WR, RAM_RD, DONE; IDLE accepts only when CPU_MIO=1.
REQ-015 IDLE + RAM write -> RAM_WR: ram_we=1 for exactly that one cycle, then DONE.
REQ-016 IDLE + RAM read -> RAM_RD for RAM_LAT cycles (wait counter); ram_dout captured into Data_in on the last RAM_RD cycle, then DONE.
REQ-017 IDLE + peripheral/unmapped access -> DONE directly; register writes take effect on the accepting edge; read data latched on that edge.
REQ-018 DONE SHALL assert MIO_ready=1 for exactly one cycle and return to IDLE unconditionally; a request still high in the following IDLE cycle starts a new transaction.
REQ-019 Data_in SHALL hold its value from DONE until the next read completes; writes do not alter Data_in.
REQ-020 led/sw: write loads led from Data_out[15:0]; read returns {16'h0, sw}.
REQ-021 seg: write loads all 32 bits; read returns seg.
REQ-022 Counter: 32-bit, increments by 1 every cycle, wraps 0xFFFFFFFF -> 0; write loads Data_out; load and increment in the same cycle -> load wins (next value = Data_out); read returns value at acceptance edge.
REQ-023 Unmapped read SHALL return 0x00000000; unmapped read or write SHALL set bus_err, sticky until reset; completes in the same latency as peripherals.
REQ-024 Latency from acceptance to MIO_ready: RAM write 2 cycles, RAM read RAM_LAT+1 cycles, peripheral/unmapped 1 cycle.
REQ-025 ram_we SHALL never be high outside RAM_WR; no RAM access for non-RAM addresses.

Reset
REQ-026 reset=1 SHALL force state IDLE, wait counter 0, MIO_ready 0, ram_we 0, Data_in 0, led 0, seg 0, counter 0, bus_err 0, ram_addr 0, ram_din 0.
REQ-027 reset asserted mid-transaction SHALL abort it with no MIO_ready pulse and no further ram_we; reset wins over any simultaneous request or counter load.

Verification
REQ-028 RAM read, RAM_LAT=2, Addr_out=0x00000010, ram_dout=0x12345678 -> ram_addr=4, MIO_ready pulse 3 cycles after acceptance, Data_in=0x12345678.
REQ-029 RAM write Addr_out=0x00000FFC, Data_out=0xA5A5A5A5 -> ram_addr=0x3FF, ram_we one cycle, MIO_ready 2 cycles after acceptance.
REQ-030 Write 0xF0000000 data 0x0001ABCD -> led=0xABCD; read same with sw=0x00FF -> Data_in=0x000000FF, MIO_ready 1 cycle after acceptance.
REQ-031 Write 0xFFFFFFFE to counter at 0xF0000004, read back after 3 cycles -> wrap to 0x00000000 observed within expected count; load-vs-increment collision yields loaded value.
REQ-032 Read 0x50000000 -> Data_in=0, bus_err=1 and stays 1 through later legal accesses until reset.
REQ-033 Assert reset during RAM_RD -> no MIO_ready, ram_we=0, all outputs at reset values next cycle; next request handled normally.
